uart_rx_stats_fifo: RTL
=======================

# uart_rx_stats_fifo

Receive-side buffer and link-statistics block sitting directly downstream of `uart_rx` in the UART/SECDED link. It captures each decoded byte together with its error classification into a FIFO, drained by a simple read handshake, and keeps saturating counters of total, corrected, uncorrectable and dropped frames. It replaces the direct `uart_rx` → receiver-memory connection whenever the consumer needs back-pressure tolerance and error visibility.

## Interface
Parameters:
- `DEPTH`, 16: FIFO entries; power of two, ≥ 2.
- `CNT_W`, 16: width of each statistics counter.
- `DROP_UNCORR`, 0: 1 = uncorrectable frames are counted but not written to the FIFO.

Ports:
- `clk`  in  1  single system clock, all logic on rising edge.
- `rst`  in  1  reset: synchronous, active-high.
- `rx_data`  in  8  decoded byte from `uart_rx`.
- `rx_valid`  in  1  `ready_rx` from `uart_rx`; may stay high for several cycles per frame.
- `err_detected`  in  1  SECDED syndrome non-zero.
- `err_corrected`  in  1  single-bit error corrected.
- `err_overall`  in  1  overall-parity mismatch.
- `rd_en`  in  1  read request.
- `rd_data`  out  8  byte read from the FIFO.
- `rd_status`  out  3  `{overall, class[1:0]}` for `rd_data`.
- `rd_valid`  out  1  one-cycle pulse: `rd_data`/`rd_status` updated.
- `empty`  out  1  FIFO holds 0 entries.
- `full`  out  1  FIFO holds `DEPTH` entries.
- `level`  out  clog2(DEPTH)+1  current occupancy.
- `clr_stats`  in  1  synchronous clear of all counters.
- `frame_cnt`, `corr_cnt`, `uncorr_cnt`, `drop_cnt`  out  CNT_W each  statistics.

## Operation
- Frame capture: a frame is accepted on the cycle where `rx_valid`=1 and its registered previous value was 0 (rising-edge detect); `rx_data` and error flags are sampled in that same cycle. Holding `rx_valid` high produces exactly one frame.
- Classification: class 00 = clean (`err_detected`=0); 01 = corrected (`err_detected`=1, `err_corrected`=1); 10 = uncorrectable (`err_detected`=1, `err_corrected`=0); 11 never produced. `overall` = sampled `err_overall`, stored unmodified.
- Entry = 11 bits `{overall, class, data}`; storage is a circular buffer with wrapping write and read pointers of width clog2(DEPTH), plus a separate occupancy counter.
- Write: on an accepted frame, written unless (class 10 and `DROP_UNCORR`=1) or FIFO full with no read in that cycle. A full-FIFO rejection increments `drop_cnt`; existing contents are untouched. The policy discard of a class-10 frame does not count as a drop.
- Read: `rd_en`=1 with `empty`=0 pops the head into `rd_data`/`rd_status` and pulses `rd_valid`. `rd_en` while empty is ignored: no pulse, outputs hold.
- Simultaneous read and write: both happen. When full, the read frees the slot and the write is accepted (no drop). When empty, the write is stored and the read is ignored (no fall-through).
- Counters: `frame_cnt` increments on every accepted frame, including dropped and discarded ones. `corr_cnt` increments on class 01 and `uncorr_cnt` on class 10, independent of FIFO space. All counters saturate at 2^CNT_W−1 and never wrap.
- `clr_stats` zeroes all four counters and has priority over an increment in the same cycle; that event is lost. It does not affect the FIFO.

## Timing
- Reset values: `rd_data`=0, `rd_status`=0, `rd_valid`=0, `empty`=1, `full`=0, `level`=0, all counters 0, pointers 0, edge-detect register 0. Reset also clears the FIFO.
- Reset has priority over every other input. A frame whose `rx_valid` edge coincides with `rst` is lost. If `rx_valid` is still high after reset, no frame is captured until it falls and rises again.
- Write latency: `level`/`empty`/`full` reflect an accepted frame on the cycle after the `rx_valid` rising edge.
- Read latency: `rd_data`, `rd_status` and `rd_valid` are registered and valid the cycle after `rd_en`. `level` decrements in that same cycle.
- Back-to-back `rd_en` every cycle yields one entry per cycle in FIFO order.
- Counter updates are visible one cycle after the capturing edge.
- All outputs are registered; there are no combinational input-to-output paths.

## Test plan
- Reset, then frames 0x41, 0x42, 0x43 clean with `rx_valid` held high 3 cycles each → `level`=3 and `frame_cnt`=3. Three `rd_en` pulses return 0x41, 0x42, 0x43, each with status 000 and one `rd_valid` each.
- Frame 0x55 with `err_detected`=1, `err_corrected`=1, then frame 0xAA with `err_detected`=1, `err_corrected`=0, `err_overall`=1 (`DROP_UNCORR`=0) → reads give 0x55/001 and 0xAA/110. `corr_cnt`=1, `uncorr_cnt`=1.
- Same uncorrectable frame with `DROP_UNCORR`=1 → `level` stays 0, `uncorr_cnt`=1, `drop_cnt`=0.
- Write 17 frames with no reads, `DEPTH`=16 → `full`=1, `level`=16, `drop_cnt`=1. Reading all 16 returns the first 16 bytes in order, then `empty`=1.
- With the FIFO full, `rx_valid` rising edge and `rd_en` in the same cycle → `level` stays 16, `drop_cnt` unchanged, the oldest byte is read. 20 more write/read pairs exercise pointer wrap with data in order.
- With `CNT_W`=4, 20 clean frames → `frame_cnt`=15 (saturated). Then `clr_stats` coincident with a frame edge → all counters 0 after the edge, and the frame is stored in the FIFO.

Source files
------------

// File: rtl/uart_rx_stats_fifo.sv
// -----------------------------------------------------------------------------
// uart_rx_stats_fifo
//
// Receive-side buffer and link-statistics block placed directly after uart_rx.
// Each decoded byte is captured on the rising edge of rx_valid together with
// its SECDED error classification. The byte and its classification are stored
// as one 11-bit entry in a circular FIFO, which is drained by a read-enable
// handshake. Saturating counters track the number of total, corrected,
// uncorrectable and dropped frames.
//
// Parameters
//   DEPTH        FIFO entries (power of two, >= 2)
//   CNT_W        width of each statistics counter
//   DROP_UNCORR  1: uncorrectable frames are counted but never stored
//
// Ports
//   clk            system clock; all logic updates on the rising edge
//   rst            synchronous active-high reset; overrides every other input
//   rx_data        decoded byte from uart_rx
//   rx_valid       ready_rx from uart_rx (level; one frame per rising edge)
//   err_detected   SECDED syndrome non-zero
//   err_corrected  single-bit error was corrected
//   err_overall    overall-parity mismatch, stored unmodified
//   rd_en          pop request; ignored while empty
//   rd_data        popped byte (registered, holds between pops)
//   rd_status      {overall, class[1:0]} of rd_data
//   rd_valid       one-cycle pulse when rd_data/rd_status were updated
//   empty, full    occupancy flags (registered)
//   level          current occupancy, 0..DEPTH
//   clr_stats      synchronous clear of all counters; wins over increments
//   frame_cnt      every accepted frame, including dropped and discarded ones
//   corr_cnt       frames classified as corrected
//   uncorr_cnt     frames classified as uncorrectable
//   drop_cnt       frames rejected because the FIFO was full
// -----------------------------------------------------------------------------
module uart_rx_stats_fifo #(
  parameter int DEPTH       = 16,
  parameter int CNT_W       = 16,
  parameter bit DROP_UNCORR = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst,

  input  logic [7:0]               rx_data,
  input  logic                     rx_valid,
  input  logic                     err_detected,
  input  logic                     err_corrected,
  input  logic                     err_overall,

  input  logic                     rd_en,
  output logic [7:0]               rd_data,
  output logic [2:0]               rd_status,
  output logic                     rd_valid,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level,

  input  logic                     clr_stats,
  output logic [CNT_W-1:0]         frame_cnt,
  output logic [CNT_W-1:0]         corr_cnt,
  output logic [CNT_W-1:0]         uncorr_cnt,
  output logic [CNT_W-1:0]         drop_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] DEPTH_L = LVL_W'(DEPTH);

  // Error classification as stored in the entry; 2'b11 is never produced.
  typedef enum logic [1:0] {
    CLS_CLEAN  = 2'b00,
    CLS_CORR   = 2'b01,
    CLS_UNCORR = 2'b10
  } err_class_e;

  typedef struct packed {
    logic       overall;
    err_class_e cls;
    logic [7:0] data;
  } entry_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic             rx_valid_q;   // previous rx_valid sample (edge detect)
  logic             rx_hold;      // rx_valid was high across reset release
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  entry_t           mem [DEPTH];

  // ---------------------------------------------------------------------------
  // Frame capture and classification
  // ---------------------------------------------------------------------------
  logic       frame_rise;
  err_class_e frame_cls;
  entry_t     wr_entry;
  entry_t     head;

  // A level still high when reset releases must not look like a new frame,
  // so rx_hold masks the edge until rx_valid has been seen low once.
  assign frame_rise = rx_valid & ~rx_valid_q & ~rx_hold;

  always_comb begin
    // NOTE: the default assignment first guarantees every path assigns
    // frame_cls, so no latch is inferred for the unlisted cases.
    frame_cls = CLS_CLEAN;
    if (err_detected) begin
      frame_cls = err_corrected ? CLS_CORR : CLS_UNCORR;
    end
  end

  assign wr_entry = '{overall: err_overall, cls: frame_cls, data: rx_data};
  assign head     = mem[rd_ptr];

  // ---------------------------------------------------------------------------
  // FIFO control
  // ---------------------------------------------------------------------------
  logic discard;  // policy discard of an uncorrectable frame (not a drop)
  logic do_rd;
  logic do_wr;
  logic do_drop;
  logic [LVL_W-1:0] level_nxt;

  assign discard = frame_rise & DROP_UNCORR & (frame_cls == CLS_UNCORR);
  assign do_rd   = rd_en & ~empty;
  // A read in the same cycle frees a slot, so a full FIFO still accepts.
  assign do_wr   = frame_rise & ~discard & (~full | do_rd);
  assign do_drop = frame_rise & ~discard & full & ~do_rd;

  always_comb begin
    level_nxt = level;
    case ({do_wr, do_rd})
      2'b10:   level_nxt = level + 1'b1;
      2'b01:   level_nxt = level - 1'b1;
      default: level_nxt = level;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_valid_q <= 1'b0;
      rx_hold    <= rx_valid;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      empty      <= 1'b1;
      full       <= 1'b0;
      rd_valid   <= 1'b0;
      rd_data    <= '0;
      rd_status  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      rx_valid_q <= rx_valid;
      rx_hold    <= rx_hold & rx_valid;
      rd_valid   <= do_rd;
      if (do_wr) begin
        wr_ptr <= wr_ptr + 1'b1;  // DEPTH is a power of two: wraps naturally
      end
      if (do_rd) begin
        rd_ptr    <= rd_ptr + 1'b1;
        rd_data   <= head.data;
        rd_status <= {head.overall, head.cls};
      end
      level <= level_nxt;
      empty <= (level_nxt == '0);
      full  <= (level_nxt == DEPTH_L);
    end
  end

  // NOTE: the storage array has no reset; the pointers and level decide which
  // slots are valid, so stale contents are never presented.
  // A write to the slot being read in the same cycle (full FIFO) is safe: the
  // read above sees the old entry, the new one lands after the edge.
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr] <= wr_entry;
    end
  end

  // ---------------------------------------------------------------------------
  // Statistics
  // ---------------------------------------------------------------------------
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Clear wins over any increment in the same cycle; that event is lost.
  always_ff @(posedge clk) begin
    if (rst || clr_stats) begin
      frame_cnt  <= '0;
      corr_cnt   <= '0;
      uncorr_cnt <= '0;
      drop_cnt   <= '0;
    end else begin
      if (frame_rise) begin
        frame_cnt <= sat_inc(frame_cnt);
      end
      if (frame_rise && frame_cls == CLS_CORR) begin
        corr_cnt <= sat_inc(corr_cnt);
      end
      if (frame_rise && frame_cls == CLS_UNCORR) begin
        uncorr_cnt <= sat_inc(uncorr_cnt);
      end
      if (do_drop) begin
        drop_cnt <= sat_inc(drop_cnt);
      end
    end
  end

endmodule
